// File: rtl/brlite_svc_buffer_pkg.sv
// Shared types for the BrLite service-receive buffer: router-side flit,
// NI-side service entry and the service class encoding.
package brlite_svc_buffer_pkg;

   typedef enum logic [1:0] {
      BR_SVC_TGT   = 2'd0,
      BR_SVC_ALL   = 2'd1,
      BR_SVC_MON   = 2'd2,
      BR_SVC_CLEAR = 2'd3
   } brlite_service_t;

   typedef struct packed {
      logic [7:0]  ksvc;
      logic [15:0] seq_source;
      logic [15:0] producer;
      logic [31:0] payload;
   } brlite_svc_t;

   typedef struct packed {
      brlite_service_t service;
      logic [7:0]      ksvc;
      logic [15:0]     seq_source;
      logic [15:0]     producer;
      logic [31:0]     payload;
   } brlite_in_t;

   localparam int SVC_W = $bits(brlite_svc_t);

   // Monitor and clear flits are housekeeping traffic and never reach the CPU.
   function automatic logic is_drop_service(input brlite_service_t s);
      return (s == BR_SVC_MON) || (s == BR_SVC_CLEAR);
   endfunction

   function automatic brlite_svc_t strip_service(input brlite_in_t f);
      brlite_svc_t r;
      r.ksvc       = f.ksvc;
      r.seq_source = f.seq_source;
      r.producer   = f.producer;
      r.payload    = f.payload;
      return r;
   endfunction

endpackage

// File: rtl/brlite_svc_buffer_if.sv
// Router-side req/ack flit channel plus NI-side service-receive view.
// Signal suffixes are from the buffer's point of view.
interface brlite_svc_buffer_if #(
   parameter int DEPTH      = 8,
   parameter int DROP_CNT_W = 16
);
   import brlite_svc_buffer_pkg::*;

   logic                    br_req_i;
   logic                    br_ack_o;
   brlite_in_t              br_data_i;
   logic                    br_svc_rx_o;
   logic                    br_svc_ack_i;
   brlite_svc_t             br_svc_data_o;
   logic [$clog2(DEPTH):0]  level_o;
   logic [DROP_CNT_W-1:0]   drop_cnt_o;

   modport slave (
      input  br_req_i, br_data_i, br_svc_ack_i,
      output br_ack_o, br_svc_rx_o, br_svc_data_o, level_o, drop_cnt_o
   );

   modport master (
      output br_req_i, br_data_i, br_svc_ack_i,
      input  br_ack_o, br_svc_rx_o, br_svc_data_o, level_o, drop_cnt_o
   );

endinterface

// File: rtl/brlite_svc_buffer_fifo.sv
// Generic power-of-two FIFO with separate occupancy counter and a
// combinational read of the head entry.
module brlite_svc_buffer_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 72
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; the pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/brlite_svc_buffer.sv
// Receive buffer between the BrLite router local port and the NI service MMRs:
// handshake, service classification, discard counter; storage in the FIFO.
module brlite_svc_buffer
   import brlite_svc_buffer_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DROP_CNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   brlite_svc_buffer_if.slave bus
);

   logic                    r_ack;
   logic [DROP_CNT_W-1:0]   r_drop_cnt;

   logic                    w_is_drop;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_accept;
   logic                    w_push;
   logic [$clog2(DEPTH):0]  w_level;
   brlite_svc_t             w_head;

   assign w_is_drop = is_drop_service(bus.br_data_i.service);
   // The ack guard stops a second accept while the router is still lowering req.
   assign w_accept  = bus.br_req_i && !r_ack && (w_is_drop || !w_full);
   assign w_push    = w_accept && !w_is_drop;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ack      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_ack <= w_accept;
         if (w_accept && w_is_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   brlite_svc_buffer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SVC_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_data  (strip_service(bus.br_data_i)),
      .i_pop   (bus.br_svc_ack_i),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign bus.br_ack_o      = r_ack;
   assign bus.br_svc_rx_o   = !w_empty;
   assign bus.br_svc_data_o = w_head;
   assign bus.level_o       = w_level;
   assign bus.drop_cnt_o    = r_drop_cnt;

endmodule
